// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite-OAM DMA bus master (256-byte page copy into PPU OAMDATA)
//
// Optional feature macro: OAM_DMA_ALIGN_EN
//   defined     : parity bit and ALIGN state present; a transfer whose HALT cycle
//                 lands on parity 0 inserts one dummy cycle so reads fall on parity 0.
//   not defined : HALT always goes straight to READ.
//
// Ports:
//   i_clk      system clock (CPU cycle rate)
//   i_reset    synchronous active-high reset
//   i_start    one-cycle strobe from the decoder on a CPU write to $4014
//   i_page     source page, sampled with i_start
//   o_halt     holds the CPU and claims the bus
//   o_busy     transfer in progress (same as o_halt)
//   o_bus_en   this block drives address/rw/data this cycle
//   o_address  bus address
//   o_rw       1 = read, 0 = write
//   o_data     write data
//   i_data     read data returned by the bus on read cycles

module oam_dma #(
    parameter logic [15:0] TARGET_ADDR = 16'h2004,
    parameter int          LENGTH      = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_page,
    output logic        o_halt,
    output logic        o_busy,
    output logic        o_bus_en,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    input  logic [7:0]  i_data
);

    localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
`ifdef OAM_DMA_ALIGN_EN
        S_ALIGN,
`endif
        S_READ,
        S_WRITE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_index;
    logic        r_halt;
    logic        r_bus_en;
    logic [15:0] r_address;
    logic        r_rw;
    logic [7:0]  r_data;
`ifdef OAM_DMA_ALIGN_EN
    logic        r_parity;
`endif

    state_t      w_state_next;
    logic [7:0]  w_page_next;
    logic [7:0]  w_index_next;
    logic        w_halt_next;
    logic        w_bus_en_next;
    logic [15:0] w_address_next;
    logic        w_rw_next;
    logic [7:0]  w_data_next;

    // Next state plus the output values for the cycle that state occupies;
    // outputs are therefore registered alongside the state.
    always_comb begin
        w_state_next   = r_state;
        w_page_next    = r_page;
        w_index_next   = r_index;
        w_data_next    = r_data;
        w_address_next = r_address;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_page_next  = i_page;
                    w_index_next = 8'h00;
                    w_state_next = S_HALT;
                end
            end
            S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                // Reads must land on parity 0; READ follows HALT, so HALT on
                // parity 0 would put the first READ on parity 1.
                w_state_next = r_parity ? S_READ : S_ALIGN;
`else
                w_state_next = S_READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            S_ALIGN: w_state_next = S_READ;
`endif
            S_READ: begin
                w_data_next  = i_data;
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                if (r_index == LAST_INDEX) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_index_next = r_index + 8'd1;
                    w_state_next = S_READ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        w_halt_next   = (w_state_next != S_IDLE);
        w_bus_en_next = (w_state_next == S_READ) || (w_state_next == S_WRITE);
        w_rw_next     = (w_state_next != S_WRITE);
        if (w_state_next == S_READ) begin
            // 8-bit index concatenated under the page: never carries out of the page.
            w_address_next = {w_page_next, w_index_next};
        end else if (w_state_next == S_WRITE) begin
            w_address_next = TARGET_ADDR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_page    <= 8'h00;
            r_index   <= 8'h00;
            r_halt    <= 1'b0;
            r_bus_en  <= 1'b0;
            r_address <= 16'h0000;
            r_rw      <= 1'b1;
            r_data    <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_page    <= w_page_next;
            r_index   <= w_index_next;
            r_halt    <= w_halt_next;
            r_bus_en  <= w_bus_en_next;
            r_address <= w_address_next;
            r_rw      <= w_rw_next;
            r_data    <= w_data_next;
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    // Free-running CPU get/put cycle parity.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
        end
    end
`endif

    assign o_halt    = r_halt;
    assign o_busy    = r_halt;
    assign o_bus_en  = r_bus_en;
    assign o_address = r_address;
    assign o_rw      = r_rw;
    assign o_data    = r_data;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for oam_dma against a page-copy reference model

module tb_oam_dma;

    localparam logic [15:0] TARGET = 16'h2004;
    localparam int          LEN    = 256;
`ifdef OAM_DMA_ALIGN_EN
    localparam int ALIGN_EN = 1;
`else
    localparam int ALIGN_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_page;
    logic        o_halt;
    logic        o_busy;
    logic        o_bus_en;
    logic [15:0] o_address;
    logic        o_rw;
    logic [7:0]  o_data;
    logic [7:0]  i_data;

    always #5 clk = ~clk;

    oam_dma #(.TARGET_ADDR(TARGET), .LENGTH(LEN)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_page(i_page),
        .o_halt(o_halt), .o_busy(o_busy), .o_bus_en(o_bus_en),
        .o_address(o_address), .o_rw(o_rw), .o_data(o_data), .i_data(i_data)
    );

    // CPU address space seen by the DMA reads.
    logic [7:0] mem [0:65535];
    assign i_data = mem[o_address];

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        bit          chk_d;
    } bus_t;

    bus_t exp_q[$];
    int   exp_len_q[$];
    int   exp_first_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rst_cyc = 0;
    bit abort = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every driven bus cycle must match the next expected transaction;
    // each halt window must have the expected length and first-read offset.
    bus_t e;
    bit   in_halt = 1'b0;
    int   hcnt = 0;
    int   first_bus = 0;

    always @(negedge clk) begin
        if (abort) begin
            abort   = 1'b0;
            in_halt = 1'b0;
        end else begin
            if (o_bus_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bus_cycle", {o_rw, 15'd0, o_address}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_addr", o_address, e.a);
                    check("bus_rw", o_rw, e.rw);
                    if (e.chk_d) check("bus_wdata", o_data, e.d);
                end
            end
            if (o_halt) begin
                if (!in_halt) begin
                    in_halt   = 1'b1;
                    hcnt      = 0;
                    first_bus = 0;
                end
                hcnt++;
                if (o_bus_en && first_bus == 0) first_bus = hcnt;
            end else if (in_halt) begin
                in_halt = 1'b0;
                if (exp_len_q.size() == 0) begin
                    check("unexpected_halt_window", hcnt, 0);
                end else begin
                    check("halt_length", hcnt, exp_len_q.pop_front());
                    check("first_read_offset", first_bus, exp_first_q.pop_front());
                end
            end
        end
    end

    // Reference model of one transfer: LEN read/write pairs from the page,
    // halt = 1 + align + 2*LEN, align when the HALT cycle falls on even parity.
    task automatic push_xfer(input logic [7:0] p, input int start_edge);
        int       align;
        bus_t     t;
        logic [15:0] src;
        align = (ALIGN_EN != 0 && ((start_edge - rst_cyc) % 2) == 0) ? 1 : 0;
        for (int i = 0; i < LEN; i++) begin
            src = {p, 8'(i)};
            t.a = src;    t.rw = 1'b1; t.d = 8'h00;    t.chk_d = 1'b0; exp_q.push_back(t);
            t.a = TARGET; t.rw = 1'b0; t.d = mem[src];  t.chk_d = 1'b1; exp_q.push_back(t);
        end
        exp_len_q.push_back(1 + align + 2 * LEN);
        exp_first_q.push_back(2 + align);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        @(posedge clk); #1;
        rst_cyc = cyc;
        i_reset = 1'b0;
        exp_q.delete();
        exp_len_q.delete();
        exp_first_q.delete();
        abort = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"},    o_halt,    1'b0);
        check({tag, "_busy"},    o_busy,    1'b0);
        check({tag, "_bus_en"},  o_bus_en,  1'b0);
        check({tag, "_address"}, o_address, 16'h0000);
        check({tag, "_rw"},      o_rw,      1'b1);
        check({tag, "_data"},    o_data,    8'h00);
    endtask

    // want_par: parity of the HALT cycle to aim for, or -1 for "start now".
    task automatic start_xfer(input logic [7:0] p, input int want_par);
        if (want_par >= 0 && ((cyc + 1 - rst_cyc) % 2) != want_par) begin
            @(posedge clk); #1;
        end
        i_start = 1'b1;
        i_page  = p;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_page  = 8'($urandom);
        push_xfer(p, cyc);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (o_halt && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) check("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        int w;
        int t;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        i_reset = 1'b0;
        i_start = 1'b0;
        i_page  = 8'h00;
        @(posedge clk); #1;

        // Reset state, with a coincident start that must lose to reset.
        i_start = 1'b1;
        i_page  = 8'h44;
        do_reset();
        i_start = 1'b0;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        check("idle_after_reset_start", o_halt, 1'b0);

        // Basic copy, HALT on odd parity.
        start_xfer(8'h02, 1);
        wait_idle();

        // Alignment case, HALT on even parity.
        start_xfer(8'h30, 0);
        wait_idle();

        // Page wrap at the top of memory.
        start_xfer(8'hFF, -1);
        wait_idle();

        // Start while busy is ignored.
        start_xfer(8'h03, -1);
        repeat (98) begin @(posedge clk); #1; end
        i_start = 1'b1;
        i_page  = 8'h07;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_idle();

        // Back-to-back: start in the cycle o_halt falls.
        start_xfer(8'h11, -1);
        wait_idle();
        start_xfer(8'h12, -1);
        check("b2b_halt_next_cycle", o_halt, 1'b1);
        wait_idle();

        // Reset during the WRITE of index 40.
        start_xfer(8'h05, -1);
        w = 0;
        t = 0;
        while (t < 300 && !(o_bus_en && !o_rw && w == 40)) begin
            if (o_bus_en && !o_rw) w++;
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) check("reset_mid_wait_timeout", 1, 0);
        do_reset();
        check_reset_outputs("mid_reset");
        start_xfer(8'h06, -1);
        wait_idle();

        // Randomized pages and start gaps.
        repeat (4) begin
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
            start_xfer(8'($urandom), -1);
            wait_idle();
        end

        repeat (4) begin @(posedge clk); #1; end
        check("leftover_bus_txns", exp_q.size(), 0);
        check("leftover_halt_windows", exp_len_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
